seq_code_lock: RTL
==================

Name: seq_code_lock

Overview:
Sequential, parametrised successor to the single-shot 4-bit combination check. It accepts a multi-digit code entered one debounced digit at a time and compares it with a stored code. On a match it drives a timed open pulse. Consecutive failures are counted, and reaching the limit triggers a timed alarm lockout. The stored code can be reprogrammed while the lock is open. The block sits between the debounced switch/key front end and the LED/actuator outputs.

Parameters:
DIGIT_W, 4, bits per entered digit
CODE_LEN, 4, digits per code; stored code width CW = DIGIT_W*CODE_LEN
DEFAULT_CODE, 16'h1234, code loaded at reset (width CW)
MAX_TRIES, 3, consecutive failures that trigger lockout (>=1)
OPEN_CYCLES, 50_000_000, clock cycles the open state is held
LOCK_CYCLES, 250_000_000, clock cycles the alarm lockout is held

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
digit_in  in  DIGIT_W  digit value, sampled when digit_valid=1
digit_valid  in  1  one-cycle pulse from debouncer: push digit_in
enter  in  1  one-cycle pulse: evaluate entry (open-enable key)
clear  in  1  one-cycle pulse: discard partial entry
prog_en  in  1  level: in OPEN, enter stores the entry as the new code
open  out  1  lock open, registered
alarm  out  1  alarm/lockout active, registered
led1  out  1  ~open (LED lit = locked)
led2  out  1  ~alarm (LED lit = alarm)
tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts before lockout
entry_cnt  out  $clog2(CODE_LEN+1)  digits currently held

Behaviour:
- Reset: state=IDLE, code_reg=DEFAULT_CODE, entry shift register=0, entry_cnt=0, fail_cnt=0, timer=0, open=0, alarm=0, led1=1, led2=1, tries_left=MAX_TRIES.
- Entry register: a digit_valid pulse shifts left by DIGIT_W, inserts digit_in at the LSBs and increments entry_cnt.
  - Once entry_cnt=CODE_LEN, further digits are ignored (no wrap, no overwrite).
- Input priority per cycle: rst > clear > enter > digit_valid.
  - clear zeroes the entry and entry_cnt; it does not touch fail_cnt.
- States:
  - IDLE:
    - enter with entry_cnt=CODE_LEN and entry==code_reg -> OPEN. Then open=1 on the cycle after enter, fail_cnt=0, timer=0, entry cleared.
    - enter with a mismatch or entry_cnt<CODE_LEN counts as a failure: fail_cnt+1 and entry cleared.
    - If the new fail_cnt equals MAX_TRIES -> ALARM. Then alarm=1 on the cycle after enter and timer=0. Otherwise remain in IDLE.
  - OPEN:
    - open=1. The timer counts each cycle; when timer reaches OPEN_CYCLES-1 -> IDLE, and open=0 on the following cycle. Open is held exactly OPEN_CYCLES cycles.
    - Digits are accepted.
    - enter with prog_en=1 and entry_cnt=CODE_LEN: code_reg<=entry, entry cleared, stay OPEN, timer restarts at 0.
    - enter with prog_en=1 and entry_cnt<CODE_LEN: entry cleared, code unchanged.
    - enter with prog_en=0: ignored except that the entry is cleared.
    - Failures are never counted in OPEN.
  - ALARM:
    - alarm=1, open=0. digit_valid, enter, clear and prog_en are all ignored, and the entry is held at 0.
    - The timer counts to LOCK_CYCLES-1 -> IDLE, with alarm=0, fail_cnt=0 and tries_left=MAX_TRIES on the following cycle.
- open and alarm are never both 1.
- tries_left = MAX_TRIES - fail_cnt, registered with fail_cnt.
- Timer width is $clog2(max(OPEN_CYCLES,LOCK_CYCLES)). The timer is zeroed on every state entry.
- A reset mid-open or mid-alarm returns everything to the reset values on the next edge and restores code_reg to DEFAULT_CODE.

Test Plan:
Bench overrides OPEN_CYCLES=8 and LOCK_CYCLES=16; other parameters stay at defaults (code 1234, MAX_TRIES=3).
1. Correct code: digits 1,2,3,4 then enter -> open=1 and led1=0 from the next cycle for exactly 8 cycles, then open=0; tries_left stays 3.
2. Wrong code twice, then correct: entries 1,2,3,5 and 9,9,9,9 -> tries_left 2 then 1; entry 1,2,3,4 -> open=1 and tries_left=3.
3. Lockout: three wrong entries -> alarm=1 and led2=0 on the cycle after the third enter, held 16 cycles. During alarm, 1,2,3,4 plus enter has no effect. Afterwards alarm=0 and tries_left=3.
4. Short entry and overflow:
   - Digits 1,2,3 then enter -> counted as a failure.
   - Digits 1,2,3,4,7 then enter -> the 7 is ignored, entry_cnt stays 4, and open=1.
5. Priority: clear and digit_valid in the same cycle -> entry_cnt=0. digit_valid and enter in the same cycle -> the digit is dropped and enter is evaluated.
6. Reprogram:
   - In OPEN, set prog_en=1, enter digits 0,5,0,5, then enter -> the timer restarts and the lock stays open 8 more cycles.
   - Later, 0,5,0,5 opens the lock and 1,2,3,4 fails.
   - A reset restores 1,2,3,4.

Source files
------------

// File: rtl/seq_code_lock.sv
// Sequential multi-digit code lock: compares a keyed-in code against a stored,
// reprogrammable code and drives timed open and alarm-lockout outputs.
module seq_code_lock #(
    parameter int DIGIT_W = 4,
    parameter int CODE_LEN = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_TRIES = 3,
    parameter int OPEN_CYCLES = 50_000_000,
    parameter int LOCK_CYCLES = 250_000_000,
    localparam int CW = DIGIT_W * CODE_LEN,
    localparam int TRY_W = $clog2(MAX_TRIES + 1),
    localparam int CNT_W = $clog2(CODE_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    input  logic               enter,
    input  logic               clear,
    input  logic               prog_en,
    output logic               open,
    output logic               alarm,
    output logic               led1,
    output logic               led2,
    output logic [TRY_W-1:0]   tries_left,
    output logic [CNT_W-1:0]   entry_cnt
);

    // state | meaning
    // IDLE  | locked, collecting digits, enter evaluates the entry
    // OPEN  | lock open for OPEN_CYCLES; enter with prog_en stores a new code
    // ALARM | lockout for LOCK_CYCLES; all inputs ignored
    typedef enum logic [1:0] {IDLE, OPEN, ALARM} state_t;

    localparam int MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMR_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t           state, state_n;
    logic [CW-1:0]    code_reg, code_n;
    logic [CW-1:0]    entry, entry_n;
    logic [CNT_W-1:0] cnt_n;
    logic [TRY_W-1:0] fail_cnt, fail_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             open_n, alarm_n;
    logic             full;

    assign full = (entry_cnt == CNT_W'(CODE_LEN));
    assign led1 = ~open;
    assign led2 = ~alarm;

    always_comb begin
        state_n = state;
        code_n  = code_reg;
        entry_n = entry;
        cnt_n   = entry_cnt;
        fail_n  = fail_cnt;
        timer_n = timer;
        open_n  = open;
        alarm_n = alarm;
        case (state)
            IDLE: begin
                if (clear) begin
                    entry_n = '0;
                    cnt_n   = '0;
                end else if (enter) begin
                    entry_n = '0;
                    cnt_n   = '0;
                    if (full && entry == code_reg) begin
                        state_n = OPEN;
                        open_n  = 1'b1;
                        fail_n  = '0;
                        timer_n = '0;
                    end else begin
                        fail_n = fail_cnt + 1'b1;
                        if (fail_n == TRY_W'(MAX_TRIES)) begin
                            state_n = ALARM;
                            alarm_n = 1'b1;
                            timer_n = '0;
                        end
                    end
                end else if (digit_valid && !full) begin
                    entry_n = (entry << DIGIT_W) | CW'(digit_in);
                    cnt_n   = entry_cnt + 1'b1;
                end
            end
            OPEN: begin
                timer_n = timer + 1'b1;
                if (timer == TMR_W'(OPEN_CYCLES - 1)) begin
                    state_n = IDLE;
                    open_n  = 1'b0;
                    timer_n = '0;
                end
                if (clear) begin
                    entry_n = '0;
                    cnt_n   = '0;
                end else if (enter) begin
                    entry_n = '0;
                    cnt_n   = '0;
                    // A successful reprogram wins over an expiring timer.
                    if (prog_en && full) begin
                        code_n  = entry;
                        state_n = OPEN;
                        open_n  = 1'b1;
                        timer_n = '0;
                    end
                end else if (digit_valid && !full) begin
                    entry_n = (entry << DIGIT_W) | CW'(digit_in);
                    cnt_n   = entry_cnt + 1'b1;
                end
            end
            ALARM: begin
                entry_n = '0;
                cnt_n   = '0;
                timer_n = timer + 1'b1;
                if (timer == TMR_W'(LOCK_CYCLES - 1)) begin
                    state_n = IDLE;
                    alarm_n = 1'b0;
                    fail_n  = '0;
                    timer_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                open_n  = 1'b0;
                alarm_n = 1'b0;
                timer_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            code_reg   <= DEFAULT_CODE;
            entry      <= '0;
            entry_cnt  <= '0;
            fail_cnt   <= '0;
            timer      <= '0;
            open       <= 1'b0;
            alarm      <= 1'b0;
            tries_left <= TRY_W'(MAX_TRIES);
        end else begin
            state      <= state_n;
            code_reg   <= code_n;
            entry      <= entry_n;
            entry_cnt  <= cnt_n;
            fail_cnt   <= fail_n;
            timer      <= timer_n;
            open       <= open_n;
            alarm      <= alarm_n;
            tries_left <= TRY_W'(MAX_TRIES) - fail_n;
        end
    end

endmodule
